// File: rtl/lc3b_split_mem_responder_pkg.sv
// Shared types for the LC-3b memory responder.
// Latency: n/a (types only).
// Backpressure: n/a.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } mem_resp_state_t;

endpackage

// File: rtl/lc3b_split_mem_responder_mem_array.sv
// Single-port word array with byte-lane writes and a registered read.
// Latency: rdata reflects index one clock later.
// Backpressure: none; one access per clock.
module lc3b_mem_array
    import lc3b_types::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 we,
    input  lc3b_mem_wmask        wmask,
    input  logic [ADDR_BITS-1:0] index,
    input  lc3b_word             wdata,
    output lc3b_word             rdata
);

    lc3b_word mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we && wmask[0]) mem[index][7:0]  <= wdata[7:0];
        if (we && wmask[1]) mem[index][15:8] <= wdata[15:8];
        rdata <= mem[index];
    end

endmodule

// File: rtl/lc3b_split_mem_responder.sv
// Round-robin I/D responder over one shared word array, one access in flight.
// Latency: resp pulses LATENCY cycles after acceptance; one access per LATENCY+1 cycles.
// Backpressure: requesters hold their request until the matching resp pulse.
module lc3b_split_mem_responder
    import lc3b_types::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_read,
    input  lc3b_word      i_address,
    output lc3b_word      i_rdata,
    output logic          i_resp,
    input  logic          d_read,
    input  logic          d_write,
    input  lc3b_mem_wmask d_wmask,
    input  lc3b_word      d_address,
    input  lc3b_word      d_wdata,
    output lc3b_word      d_rdata,
    output logic          d_resp,
    output logic          busy
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    mem_resp_state_t      state;
    logic [3:0]           cnt;
    logic                 last_grant_d;
    logic                 port_d;
    logic                 op_write;
    logic [ADDR_BITS-1:0] idx_q;
    lc3b_mem_wmask        wmask_q;
    lc3b_word             wdata_q;
    lc3b_word             i_rdata_q;
    lc3b_word             d_rdata_q;

    logic                 d_req;
    logic                 grant_d;
    logic                 accept;
    logic                 arr_we;
    logic [ADDR_BITS-1:0] arr_index;
    lc3b_word             arr_rdata;
    logic                 unused_addr_bits;

    assign d_req   = d_read | d_write;
    assign grant_d = d_req & (~i_read | ~last_grant_d);
    assign accept  = (state == IDLE) & (i_read | d_req);

    // In IDLE the array is pointed at the incoming request so a LATENCY==1
    // access has its read data registered on the accepting edge.
    assign arr_index = (state != IDLE) ? idx_q :
                       grant_d         ? d_address[ADDR_BITS:1] :
                                         i_address[ADDR_BITS:1];
    assign arr_we    = (state == RESP) & op_write;

    assign i_rdata = i_resp ? arr_rdata : i_rdata_q;
    assign d_rdata = (d_resp & ~op_write) ? arr_rdata : d_rdata_q;

    assign unused_addr_bits = ^{i_address[15:ADDR_BITS+1], i_address[0],
                                d_address[15:ADDR_BITS+1], d_address[0]};

    lc3b_mem_array #(.ADDR_BITS(ADDR_BITS)) u_array (
        .clk   (clk),
        .we    (arr_we),
        .wmask (wmask_q),
        .index (arr_index),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            last_grant_d <= 1'b0;
            port_d       <= 1'b0;
            op_write     <= 1'b0;
            idx_q        <= '0;
            wmask_q      <= '0;
            wdata_q      <= '0;
            i_resp       <= 1'b0;
            d_resp       <= 1'b0;
            busy         <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            if (i_resp)             i_rdata_q <= arr_rdata;
            if (d_resp && !op_write) d_rdata_q <= arr_rdata;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        port_d       <= grant_d;
                        last_grant_d <= grant_d;
                        op_write     <= grant_d & d_write;
                        idx_q        <= arr_index;
                        wmask_q      <= d_wmask;
                        wdata_q      <= d_wdata;
                        cnt          <= CNT_LOAD;
                        busy         <= 1'b1;
                        if (LATENCY == 1) begin
                            state  <= RESP;
                            i_resp <= ~grant_d;
                            d_resp <= grant_d;
                        end else begin
                            state  <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state  <= RESP;
                        i_resp <= ~port_d;
                        d_resp <= port_d;
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    i_resp <= 1'b0;
                    d_resp <= 1'b0;
                    busy   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
